// File: rtl/ov7670_axis_packer.sv
// rtl/ov7670_axis_packer.sv - OV7670 pixel packer: FWFT FIFO to AXI4-Stream video with SOF/EOL and overflow resync (option: PACKER_RGB888_EN)
module ov7670_axis_packer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DEPTH  = 16
) (
    input  logic                       cam_PCLK,
    input  logic                       rst,
    input  logic                       pix_valid,
    input  logic [15:0]                rgb565,
    input  logic [$clog2(WIDTH):0]     h_cnt,
    input  logic [$clog2(HEIGHT):0]    v_cnt,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
`ifdef PACKER_RGB888_EN
    output logic [23:0]                m_axis_tdata,
`else
    output logic [15:0]                m_axis_tdata,
`endif
    output logic                       m_axis_tuser,
    output logic                       m_axis_tlast,
    output logic                       ovf_pulse,
    output logic                       sync_lost
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(WIDTH) + 1;
    localparam logic [HW-1:0] H_LAST     = HW'(WIDTH - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q;
    logic            wr_en, rd_en, ovf_d;
    logic            sof, eol;
    logic [17:0]     mem [DEPTH];
    logic [17:0]     head;
    logic [15:0]     head_pix;

    // Frame markers are decoded once, at write time, and travel with the pixel.
    assign sof = (h_cnt == '0) && (v_cnt == '0);
    assign eol = (h_cnt == H_LAST);

    assign m_axis_tvalid = (count_q != '0);
    assign rd_en         = m_axis_tvalid && m_axis_tready;
    assign count_d       = count_q + CW'(wr_en) - CW'(rd_en);
    assign sync_lost     = (state_q != STREAM);

    // Sync FSM: decides whether the incoming pixel is written or discarded.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        ovf_d   = 1'b0;
        if (pix_valid) begin
            case (state_q)
                IDLE, DROP: begin
                    if (sof) begin
                        if (!full_q) begin
                            wr_en   = 1'b1;
                            state_d = STREAM;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (!full_q) begin
                        wr_en = 1'b1;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = DROP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, pointers, occupancy and the registered full / overflow flags.
    always_ff @(posedge cam_PCLK or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            ovf_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            full_q    <= (count_d == COUNT_FULL);
            ovf_pulse <= ovf_d;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are only meaningful while count is non-zero.
    always_ff @(posedge cam_PCLK) begin
        if (wr_en) mem[wr_ptr] <= {sof, eol, rgb565};
    end

    // Head entry falls through combinationally; outputs forced low when empty.
    assign head         = mem[rd_ptr];
    assign head_pix     = m_axis_tvalid ? head[15:0] : 16'h0000;
    assign m_axis_tuser = m_axis_tvalid & head[17];
    assign m_axis_tlast = m_axis_tvalid & head[16];

`ifdef PACKER_RGB888_EN
    assign m_axis_tdata = {head_pix[15:11], head_pix[15:13],
                           head_pix[10:5],  head_pix[10:9],
                           head_pix[4:0],   head_pix[4:2]};
`else
    assign m_axis_tdata = head_pix;
`endif

endmodule
